// File: rtl/alu_control_mdu.sv
// MIPS ALU control decoder plus an iterative multiply/divide unit writing HI/LO.
// Define ALU_DIV_EN to build the DIV/DIVU datapath; otherwise only MULT/MULTU run.
module alu_control_mdu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            ALUOp,
    input  logic [5:0]            ALUFunction,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [3:0]            ALUOperation,
    output logic                  illegal,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
`ifdef ALU_DIV_EN
        S_DIV,
`endif
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic          is_mdu;
    logic          mdu_signed;
`ifdef ALU_DIV_EN
    logic          mdu_div;
    logic          op_div;
`endif
    logic          accept;
    logic          last_iter;
    logic [2*W-1:0] acc;
    logic [W-1:0]  opnd;
    logic [CW-1:0] cnt;
    logic          neg_q;
    logic          neg_r;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic [W:0]    mul_sum;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave a latch behind.
    always_comb begin
        ALUOperation = 4'b1001;
        illegal      = 1'b0;
        is_mdu       = 1'b0;
        mdu_signed   = 1'b0;
`ifdef ALU_DIV_EN
        mdu_div      = 1'b0;
`endif
        unique case (ALUOp)
            3'b000: ALUOperation = 4'b0011;
            3'b001: ALUOperation = 4'b0100;
            3'b010: ALUOperation = 4'b0110;
            3'b011: ALUOperation = 4'b0101;
            3'b100: ALUOperation = 4'b0011;
            3'b101: ALUOperation = 4'b0001;
            3'b110: ALUOperation = 4'b0000;
            3'b111: begin
                case (ALUFunction)
                    6'h24: ALUOperation = 4'b0000;
                    6'h25: ALUOperation = 4'b0001;
                    6'h27: ALUOperation = 4'b0010;
                    6'h20: ALUOperation = 4'b0011;
                    6'h22: ALUOperation = 4'b0100;
                    6'h00: ALUOperation = 4'b1110;
                    6'h02: ALUOperation = 4'b1100;
                    6'h08: ALUOperation = 4'b0110;
                    6'h10: ALUOperation = 4'b1010;
                    6'h12: ALUOperation = 4'b1011;
                    6'h18: begin
                        ALUOperation = 4'b1000;
                        is_mdu       = 1'b1;
                        mdu_signed   = 1'b1;
                    end
                    6'h19: begin
                        ALUOperation = 4'b1000;
                        is_mdu       = 1'b1;
                    end
`ifdef ALU_DIV_EN
                    6'h1A: begin
                        ALUOperation = 4'b1000;
                        is_mdu       = 1'b1;
                        mdu_signed   = 1'b1;
                        mdu_div      = 1'b1;
                    end
                    6'h1B: begin
                        ALUOperation = 4'b1000;
                        is_mdu       = 1'b1;
                        mdu_div      = 1'b1;
                    end
`endif
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign accept    = (state == S_IDLE) && start && is_mdu;
    assign last_iter = (cnt == CW'(W - 1));
    assign a_mag     = (mdu_signed && a_i[W-1]) ? -a_i : a_i;
    assign b_mag     = (mdu_signed && b_i[W-1]) ? -b_i : b_i;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set, keeping the carry as the new top bit.
    assign mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};

`ifdef ALU_DIV_EN
    logic [W:0]   div_rs;
    logic [W-1:0] div_diff;
    logic         div_fits;

    // Restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor only when it fits.
    assign div_rs   = {acc[2*W-1:W], acc[W-1]};
    assign div_fits = (div_rs >= {1'b0, opnd});
    assign div_diff = div_rs[W-1:0] - opnd;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef ALU_DIV_EN
                    state_next = mdu_div ? S_DIV : S_MUL;
`else
                    state_next = S_MUL;
`endif
                end
            end
            S_MUL: if (last_iter) state_next = S_FIX;
`ifdef ALU_DIV_EN
            S_DIV: if (last_iter || (opnd == '0)) state_next = S_FIX;
`endif
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            opnd  <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
`ifdef ALU_DIV_EN
            op_div <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt   <= '0;
                        neg_q <= mdu_signed & (a_i[W-1] ^ b_i[W-1]);
                        neg_r <= mdu_signed & a_i[W-1];
`ifdef ALU_DIV_EN
                        op_div <= mdu_div;
                        if (mdu_div) begin
                            acc  <= {{W{1'b0}}, a_mag};
                            opnd <= b_mag;
                        end else begin
                            acc  <= {{W{1'b0}}, b_mag};
                            opnd <= a_mag;
                        end
`else
                        acc  <= {{W{1'b0}}, b_mag};
                        opnd <= a_mag;
`endif
                    end
                end
                S_MUL: begin
                    acc <= {mul_sum, acc[W-1:1]};
                    cnt <= cnt + 1'b1;
                end
`ifdef ALU_DIV_EN
                S_DIV: begin
                    if (opnd == '0) begin
                        // Rebuild the original dividend; this result bypasses sign fix-up.
                        acc   <= {(neg_r ? -acc[W-1:0] : acc[W-1:0]), {W{1'b1}}};
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else begin
                        acc <= {(div_fits ? div_diff : div_rs[W-1:0]), acc[W-2:0], div_fits};
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                S_FIX: begin
`ifdef ALU_DIV_EN
                    if (op_div) begin
                        lo <= neg_q ? -acc[W-1:0]     : acc[W-1:0];
                        hi <= neg_r ? -acc[2*W-1:W]   : acc[2*W-1:W];
                    end else begin
                        {hi, lo} <= neg_q ? -acc : acc;
                    end
`else
                    {hi, lo} <= neg_q ? -acc : acc;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Self-checking bench for alu_control_mdu: a timeline/arithmetic model compared
// every cycle, plus directed vectors with hand-computed HI/LO values.
module tb_alu_control_mdu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    ALUOp;
    logic [5:0]    ALUFunction;
    logic          start;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic [3:0]    ALUOperation;
    logic          illegal;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int checks = 0;
    int errors = 0;

    alu_control_mdu #(.DATA_WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .ALUOp       (ALUOp),
        .ALUFunction (ALUFunction),
        .start       (start),
        .a_i         (a_i),
        .b_i         (b_i),
        .ALUOperation(ALUOperation),
        .illegal     (illegal),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode table: returns {illegal, op}.
    function automatic logic [4:0] ref_decode(input logic [2:0] op, input logic [5:0] f);
        case (op)
            3'd0: return 5'h03;
            3'd1: return 5'h04;
            3'd2: return 5'h06;
            3'd3: return 5'h05;
            3'd4: return 5'h03;
            3'd5: return 5'h01;
            3'd6: return 5'h00;
            default: begin
                case (f)
                    6'h24: return 5'h00;
                    6'h25: return 5'h01;
                    6'h27: return 5'h02;
                    6'h20: return 5'h03;
                    6'h22: return 5'h04;
                    6'h00: return 5'h0E;
                    6'h02: return 5'h0C;
                    6'h08: return 5'h06;
                    6'h10: return 5'h0A;
                    6'h12: return 5'h0B;
                    6'h18, 6'h19: return 5'h08;
`ifdef ALU_DIV_EN
                    6'h1A, 6'h1B: return 5'h08;
`endif
                    default: return 5'h19;
                endcase
            end
        endcase
    endfunction

    // Arithmetic result as {HI, LO}.
    function automatic logic [63:0] ref_mdu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        logic [31:0] uq, ur;
        case (f)
            6'h18: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa * sb;
                return q;
            end
            6'h19: begin
                p = {32'b0, a} * {32'b0, b};
                return p;
            end
            6'h1A: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa / sb;
                r  = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                uq = a / b;
                ur = a % b;
                return {ur, uq};
            end
        endcase
    endfunction

    // Timeline model: accept in idle, results after lat edges, busy one more.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_res = '0;
    int          m_cnt = 0;
    int          m_lat = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (start && ref_decode(ALUOp, ALUFunction) == 5'h08) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_res  <= ref_mdu(ALUFunction, a_i, b_i);
                m_lat  <= (ALUFunction[1] && b_i == 0) ? 2 : W + 1;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_lat) begin
                m_hi   <= m_res[63:32];
                m_lo   <= m_res[31:0];
                m_done <= 1'b1;
            end
            if (m_cnt + 1 == m_lat + 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0] dec;
        dec = ref_decode(ALUOp, ALUFunction);
        check("cyc_aluoperation", ALUOperation, dec[3:0]);
        check("cyc_illegal", illegal, dec[4]);
        check("cyc_busy", busy, m_busy);
        check("cyc_done", done, m_done);
        check("cyc_hi", hi, m_hi);
        check("cyc_lo", lo, m_lo);
    end

    typedef struct packed {
        logic [2:0] op;
        logic [5:0] f;
        logic       ill;
        logic [3:0] code;
    } dvec_t;

    dvec_t dvecs [21] = '{
        '{3'd0, 6'h00, 1'b0, 4'h3}, '{3'd1, 6'h00, 1'b0, 4'h4},
        '{3'd2, 6'h00, 1'b0, 4'h6}, '{3'd3, 6'h00, 1'b0, 4'h5},
        '{3'd4, 6'h00, 1'b0, 4'h3}, '{3'd5, 6'h00, 1'b0, 4'h1},
        '{3'd6, 6'h00, 1'b0, 4'h0}, '{3'd7, 6'h24, 1'b0, 4'h0},
        '{3'd7, 6'h25, 1'b0, 4'h1}, '{3'd7, 6'h27, 1'b0, 4'h2},
        '{3'd7, 6'h20, 1'b0, 4'h3}, '{3'd7, 6'h22, 1'b0, 4'h4},
        '{3'd7, 6'h00, 1'b0, 4'hE}, '{3'd7, 6'h02, 1'b0, 4'hC},
        '{3'd7, 6'h08, 1'b0, 4'h6}, '{3'd7, 6'h18, 1'b0, 4'h8},
        '{3'd7, 6'h19, 1'b0, 4'h8}, '{3'd7, 6'h10, 1'b0, 4'hA},
        '{3'd7, 6'h12, 1'b0, 4'hB}, '{3'd7, 6'h3F, 1'b1, 4'h9},
        '{3'd7, 6'h21, 1'b1, 4'h9}
    };

    // Called at posedge+2; returns at posedge+2 of the first idle cycle.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input int exp_lat, input int extra_at);
        int k;
        ALUOp = 3'd7; ALUFunction = f; a_i = a; b_i = b; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; a_i = $urandom; b_i = $urandom;
        k = 0;
        while (!done && k < 100) begin
            if (k == extra_at) begin
                start = 1'b1; a_i = 32'd3; b_i = 32'd5;
            end
            @(posedge clk); #2;
            start = 1'b0;
            k++;
        end
        check({tag, "_latency"}, k, exp_lat);
        check({tag, "_hi"}, hi, exp[63:32]);
        check({tag, "_lo"}, lo, exp[31:0]);
        @(posedge clk); #2;
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; ALUOp = 3'd0; ALUFunction = 6'h00; a_i = '0; b_i = '0;
        #1 reset = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        #20 reset = 1'b1;

        @(posedge clk); #2;
        foreach (dvecs[i]) begin
            ALUOp = dvecs[i].op; ALUFunction = dvecs[i].f;
            #1;
            check($sformatf("dec_%0d_%02h_op", dvecs[i].op, dvecs[i].f), ALUOperation, dvecs[i].code);
            check($sformatf("dec_%0d_%02h_ill", dvecs[i].op, dvecs[i].f), illegal, dvecs[i].ill);
            @(posedge clk); #2;
        end

        run_op("mult_neg3x7", 6'h18, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 33, -1);
        run_op("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 5);
        run_op("mult_min_x_min", 6'h18, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33, -1);

`ifdef ALU_DIV_EN
        run_op("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, -1);
        run_op("divu_100_7", 6'h1B, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33, -1);
        run_op("div_by_zero", 6'h1A, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 2, -1);
        run_op("div_neg_by_zero", 6'h1A, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF, 2, -1);
        run_op("div_min_m1", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, -1);
        run_op("div_7_m2", 6'h1A, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33, -1);
`else
        ALUOp = 3'd7; ALUFunction = 6'h1A; a_i = 32'd5; b_i = 32'd0; start = 1'b1;
        #1;
        check("nodiv_illegal", illegal, 1'b1);
        check("nodiv_op", ALUOperation, 4'h9);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check("nodiv_busy", busy, 1'b0);
        end
        ALUFunction = 6'h1B;
        #1;
        check("nodivu_illegal", illegal, 1'b1);
        @(posedge clk); #2;
        check("nodivu_busy", busy, 1'b0);
        start = 1'b0;
        @(posedge clk); #2;
`endif

        // Reset in the middle of a multiply, observed without any clock edge.
        ALUOp = 3'd7; ALUFunction = 6'h18; a_i = 32'd123456; b_i = 32'd789; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        #10 reset = 1'b1;
        @(posedge clk); #2;
        run_op("mult_6x7", 6'h18, 32'd6, 32'd7, 64'd42, 33, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
